syn_clk_split: RTL and testbench

- Inverse of the global-time reconstruction path: takes the 64-bit global synchronized time and produces the cycle-relative sync clock (ns within the current synchronization cycle) plus a running cycle index.
- In 1588 (TSN) mode the time passes through unchanged.
- In 6802 (TTE) mode the output wraps to 0 at every cycle boundary.
- Sits between the global timer and the TTE schedule/dispatch logic.

---
 rtl/syn_clk_split_pkg.sv | 15 +
 rtl/syn_cycle_cmp.sv | 37 +++
 rtl/syn_clk_split.sv | 127 ++++++++++++
 tb/tb_syn_clk_split.sv | 126 ++++++++++++
 4 files changed

// File: rtl/syn_clk_split_pkg.sv
// Shared widths, mode encoding and state encoding for the sync-clock split path.
package syn_clk_split_pkg;

  localparam int unsigned CLK_W_DEF = 64;
  localparam int unsigned CYC_W_DEF = 32;

  localparam logic MODE_1588 = 1'b1;
  localparam logic MODE_6802 = 1'b0;

  typedef enum logic [0:0] {
    StInit,
    StTrack
  } state_e;

endpackage

// File: rtl/syn_cycle_cmp.sv
// Classifies global time against the current cycle base: inside the cycle,
// crossed into the next cycle, or jumped (too far forward or backward).
module syn_cycle_cmp
  import syn_clk_split_pkg::*;
#(
  parameter int unsigned CLK_W = CLK_W_DEF,
  parameter int unsigned CYC_W = CYC_W_DEF
) (
  input  logic [CLK_W-1:0] iv_global,
  input  logic [CLK_W-1:0] iv_base,
  input  logic [CYC_W-1:0] iv_cycle,
  output logic [CLK_W-1:0] ov_diff,
  output logic [CLK_W-1:0] ov_diff_sub,
  output logic             o_in_cycle,
  output logic             o_next_cycle,
  output logic             o_jump
);

  logic [CLK_W-1:0] cyc_ext;
  logic [CLK_W-1:0] two_cyc_ext;
  logic [CYC_W:0]   two_cyc;
  logic             backward;

  assign cyc_ext     = CLK_W'(iv_cycle);
  // Doubled at CYC_W+1 bits so a full-range cycle length cannot overflow.
  assign two_cyc     = {iv_cycle, 1'b0};
  assign two_cyc_ext = CLK_W'(two_cyc);

  assign backward    = iv_global < iv_base;
  assign ov_diff     = iv_global - iv_base;
  assign ov_diff_sub = ov_diff - cyc_ext;

  assign o_in_cycle   = !backward && (ov_diff < cyc_ext);
  assign o_next_cycle = !backward && (ov_diff >= cyc_ext) && (ov_diff < two_cyc_ext);
  assign o_jump       = backward || (ov_diff >= two_cyc_ext);

endmodule

// File: rtl/syn_clk_split.sv
// Splits global synchronized time into a cycle-relative sync clock and a cycle
// index (6802 mode), or passes global time straight through (1588 mode).
module syn_clk_split
  import syn_clk_split_pkg::*;
#(
  parameter int unsigned CLK_W = CLK_W_DEF,
  parameter int unsigned CYC_W = CYC_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [CLK_W-1:0] iv_global_clk,
  input  logic             i_tsn_or_tte,
  input  logic [CYC_W-1:0] iv_syn_clk_cycle,
  output logic [CLK_W-1:0] ov_syn_clk,
  output logic [CYC_W-1:0] ov_cycle_cnt,
  output logic             o_cycle_start,
  output logic             o_resync,
  output logic             o_cfg_err
);

  state_e           state_q, state_d;
  logic [CLK_W-1:0] base_q, base_d;
  logic [CLK_W-1:0] syn_q, syn_d;
  logic [CYC_W-1:0] cnt_q, cnt_d;
  logic             start_q, start_d;
  logic             resync_q, resync_d;
  logic             err_q, err_d;

  logic [CLK_W-1:0] diff;
  logic [CLK_W-1:0] diff_sub;
  logic             in_cycle;
  logic             next_cycle;
  logic             jump;

  syn_cycle_cmp #(
    .CLK_W(CLK_W),
    .CYC_W(CYC_W)
  ) u_cmp (
    .iv_global   (iv_global_clk),
    .iv_base     (base_q),
    .iv_cycle    (iv_syn_clk_cycle),
    .ov_diff     (diff),
    .ov_diff_sub (diff_sub),
    .o_in_cycle  (in_cycle),
    .o_next_cycle(next_cycle),
    .o_jump      (jump)
  );

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    syn_d    = syn_q;
    cnt_d    = cnt_q;
    start_d  = 1'b0;
    resync_d = 1'b0;
    err_d    = 1'b0;
    case (i_tsn_or_tte)
      MODE_1588: begin
        syn_d   = iv_global_clk;
        cnt_d   = '0;
        state_d = StInit;
      end
      MODE_6802: begin
        if (iv_syn_clk_cycle == '0) begin
          // Hold base, count and state so tracking resumes once fixed.
          err_d = 1'b1;
          syn_d = '0;
        end else begin
          unique case (state_q)
            StInit: begin
              base_d  = iv_global_clk;
              syn_d   = '0;
              cnt_d   = '0;
              start_d = 1'b1;
              state_d = StTrack;
            end
            StTrack: begin
              if (in_cycle) begin
                syn_d = diff;
              end else if (next_cycle) begin
                base_d  = base_q + CLK_W'(iv_syn_clk_cycle);
                syn_d   = diff_sub;
                cnt_d   = cnt_q + 1'b1;
                start_d = 1'b1;
              end else if (jump) begin
                base_d   = iv_global_clk;
                syn_d    = '0;
                cnt_d    = cnt_q + 1'b1;
                start_d  = 1'b1;
                resync_d = 1'b1;
              end
            end
            default: state_d = StInit;
          endcase
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= StInit;
      base_q   <= '0;
      syn_q    <= '0;
      cnt_q    <= '0;
      start_q  <= 1'b0;
      resync_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      syn_q    <= syn_d;
      cnt_q    <= cnt_d;
      start_q  <= start_d;
      resync_q <= resync_d;
      err_q    <= err_d;
    end
  end

  assign ov_syn_clk    = syn_q;
  assign ov_cycle_cnt  = cnt_q;
  assign o_cycle_start = start_q;
  assign o_resync      = resync_q;
  assign o_cfg_err     = err_q;

endmodule

// File: tb/tb_syn_clk_split.sv
// Directed bench for syn_clk_split: expected outputs are queued as each input
// set is driven and compared one clock later.
module tb_syn_clk_split;

  typedef struct packed {
    logic [63:0] syn;
    logic [31:0] cnt;
    logic        start;
    logic        resync;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] global_clk;
  logic        mode;
  logic [31:0] cyc;
  logic [63:0] syn;
  logic [31:0] cnt;
  logic        cyc_start;
  logic        resync;
  logic        cfg_err;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  syn_clk_split dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .iv_global_clk   (global_clk),
    .i_tsn_or_tte    (mode),
    .iv_syn_clk_cycle(cyc),
    .ov_syn_clk      (syn),
    .ov_cycle_cnt    (cnt),
    .o_cycle_start   (cyc_start),
    .o_resync        (resync),
    .o_cfg_err       (cfg_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Drive one input set, queue its expectation, then compare after the edge.
  task automatic step(input string tag, input logic r, input logic m, input logic [63:0] g,
                      input logic [31:0] c, input logic [63:0] e_syn, input logic [31:0] e_cnt,
                      input logic e_start, input logic e_resync, input logic e_err);
    exp_t e;
    exp_t got;
    rst        = r;
    mode       = m;
    global_clk = g;
    cyc        = c;
    e.syn    = e_syn;
    e.cnt    = e_cnt;
    e.start  = e_start;
    e.resync = e_resync;
    e.err    = e_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 64'd1, 64'd0);
    end else begin
      got = sb.pop_front();
      chk({tag, ".syn"}, syn, got.syn);
      chk({tag, ".cnt"}, 64'(cnt), 64'(got.cnt));
      chk({tag, ".start"}, 64'(cyc_start), 64'(got.start));
      chk({tag, ".resync"}, 64'(resync), 64'(got.resync));
      chk({tag, ".cfg_err"}, 64'(cfg_err), 64'(got.err));
    end
  endtask

  initial begin
    rst        = 1'b1;
    mode       = 1'b0;
    global_clk = '0;
    cyc        = '0;
    @(posedge clk);
    #1;

    //   tag          rst  mode global      cycle  syn         cnt start rsy err
    step("reset",     1'b1, 1'b0, 64'd777,   1000, 64'd0,      0, 0, 0, 0);
    step("pass_1234", 1'b0, 1'b1, 64'h1234,  1000, 64'h1234,   0, 0, 0, 0);
    step("pass_0",    1'b0, 1'b1, 64'd0,     1000, 64'd0,      0, 0, 0, 0);
    step("entry",     1'b0, 1'b0, 64'd5000,  1000, 64'd0,      0, 1, 0, 0);
    step("track_8",   1'b0, 1'b0, 64'd5008,  1000, 64'd8,      0, 0, 0, 0);
    step("track_16",  1'b0, 1'b0, 64'd5016,  1000, 64'd16,     0, 0, 0, 0);
    step("edge_999",  1'b0, 1'b0, 64'd5999,  1000, 64'd999,    0, 0, 0, 0);
    step("wrap",      1'b0, 1'b0, 64'd6004,  1000, 64'd4,      1, 1, 0, 0);
    step("post_wrap", 1'b0, 1'b0, 64'd6012,  1000, 64'd12,     1, 0, 0, 0);
    step("pre_jump",  1'b0, 1'b0, 64'd6100,  1000, 64'd100,    1, 0, 0, 0);
    step("fwd_jump",  1'b0, 1'b0, 64'd9000,  1000, 64'd0,      2, 1, 1, 0);
    step("post_fwd",  1'b0, 1'b0, 64'd9008,  1000, 64'd8,      2, 0, 0, 0);
    step("back_jump", 1'b0, 1'b0, 64'd100,   1000, 64'd0,      3, 1, 1, 0);
    step("cfg_err_a", 1'b0, 1'b0, 64'd200,   0,    64'd0,      3, 0, 0, 1);
    step("cfg_err_b", 1'b0, 1'b0, 64'd300,   0,    64'd0,      3, 0, 0, 1);
    step("cfg_fixed", 1'b0, 1'b0, 64'd400,   1000, 64'd300,    3, 0, 0, 0);
    // Shortened cycle: diff 350 >= 2*100 forces a resync.
    step("shorten",   1'b0, 1'b0, 64'd450,   100,  64'd0,      4, 1, 1, 0);
    step("wrap_s1",   1'b0, 1'b0, 64'd560,   100,  64'd10,     5, 1, 0, 0);
    step("wrap_s2",   1'b0, 1'b0, 64'd650,   100,  64'd0,      6, 1, 0, 0);
    step("wrap_s3",   1'b0, 1'b0, 64'd750,   100,  64'd0,      7, 1, 0, 0);
    step("mid_cyc",   1'b0, 1'b0, 64'd760,   100,  64'd10,     7, 0, 0, 0);
    step("reset_mid", 1'b1, 1'b0, 64'd770,   100,  64'd0,      0, 0, 0, 0);
    step("re_init",   1'b0, 1'b0, 64'd800,   100,  64'd0,      0, 1, 0, 0);
    step("re_track",  1'b0, 1'b0, 64'd850,   100,  64'd50,     0, 0, 0, 0);
    step("to_1588",   1'b0, 1'b1, 64'd900,   100,  64'd900,    0, 0, 0, 0);
    step("back_6802", 1'b0, 1'b0, 64'd910,   100,  64'd0,      0, 1, 0, 0);
    step("wrap_re",   1'b0, 1'b0, 64'd1020,  100,  64'd10,     1, 1, 0, 0);
    step("reset_end", 1'b1, 1'b0, 64'd1030,  100,  64'd0,      0, 0, 0, 0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
